// File: rtl/bnb_shift_pair.sv
// ---------------------------------------------------------------------------
// bnb_shift_pair
//
// Puts two registered paths side by side so that their latencies can be
// compared. Both paths take the same input.
//   - q1 path: a chain of DEPTH intermediate stages that behaves like
//     blocking assignments. Every stage takes the same value within one edge,
//     so the whole chain reduces to one register and has 1-cycle latency.
//   - q2 path: a true DEPTH-stage shift register with DEPTH-cycle latency.
//
// Parameters
//   WIDTH   data width of d, q1, q2 and of every stage (>= 1)
//   DEPTH   number of stages in the q2 path (2..16)
//
// Ports
//   clk_i    rising-edge clock for all registers
//   rst_i    asynchronous, active-high reset; clears every register
//   d_i      data input, sampled on the rising edge of clk_i
//   q1_o     output of the collapsed chain, 1 cycle after d_i
//   q2_o     output of the shift register, DEPTH cycles after d_i
//   taps_o   contents of the shift stages; stage 0 is in the LSBs and
//            stage DEPTH-1 equals q2_o
// ---------------------------------------------------------------------------
module bnb_shift_pair #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [WIDTH-1:0]       d_i,
  output logic [WIDTH-1:0]       q1_o,
  output logic [WIDTH-1:0]       q2_o,
  output logic [WIDTH*DEPTH-1:0] taps_o
);

  // Stop elaboration when a parameter is outside its legal range.
  if (WIDTH < 1) begin : g_bad_width
    $error("bnb_shift_pair: WIDTH must be at least 1");
  end
  if (DEPTH < 2 || DEPTH > 16) begin : g_bad_depth
    $error("bnb_shift_pair: DEPTH must be in the range 2..16");
  end

  // -------------------------------------------------------------------------
  // q1 path: collapsed chain
  // -------------------------------------------------------------------------
  // Each link of the chain reads the link before it within the same
  // evaluation, as a blocking chain does. The last link is therefore d_i
  // itself, and only that value needs a register.
  logic [DEPTH-1:0][WIDTH-1:0] chain_d;
  logic [WIDTH-1:0]            q1_d, q1_q;

  always_comb begin
    chain_d    = '0;
    chain_d[0] = d_i;
    for (int i = 1; i < DEPTH; i++) begin
      chain_d[i] = chain_d[i-1];
    end
    q1_d = chain_d[DEPTH-1];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q1_q <= '0;
    end else begin
      q1_q <= q1_d;
    end
  end

  // -------------------------------------------------------------------------
  // q2 path: true shift register
  // -------------------------------------------------------------------------
  // Each next stage is built only from register outputs taken before the
  // edge, so data moves forward by exactly one stage on each edge.
  logic [DEPTH-1:0][WIDTH-1:0] stage_d, stage_q;

  always_comb begin
    stage_d    = '0;
    stage_d[0] = d_i;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: driven only by registers
  // -------------------------------------------------------------------------
  assign q1_o   = q1_q;
  assign q2_o   = stage_q[DEPTH-1];
  assign taps_o = stage_q;

endmodule

// File: tb/tb_bnb_shift_pair.sv
// Directed bench for bnb_shift_pair. The main instance has DEPTH=3. Two more
// instances with DEPTH=2 and DEPTH=16 share the same stimulus for the
// parameter sweep.
module tb_bnb_shift_pair;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        d   = 1'b1;

  logic        q1_3, q2_3;
  logic [2:0]  taps_3;
  logic        q1_2, q2_2;
  logic [1:0]  taps_2;
  logic        q1_16, q2_16;
  logic [15:0] taps_16;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bnb_shift_pair #(.WIDTH(1), .DEPTH(3)) u_dut3 (
    .clk_i (clk), .rst_i (rst), .d_i (d),
    .q1_o  (q1_3), .q2_o (q2_3), .taps_o (taps_3)
  );

  bnb_shift_pair #(.WIDTH(1), .DEPTH(2)) u_dut2 (
    .clk_i (clk), .rst_i (rst), .d_i (d),
    .q1_o  (q1_2), .q2_o (q2_2), .taps_o (taps_2)
  );

  bnb_shift_pair #(.WIDTH(1), .DEPTH(16)) u_dut16 (
    .clk_i (clk), .rst_i (rst), .d_i (d),
    .q1_o  (q1_16), .q2_o (q2_16), .taps_o (taps_16)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic       d;
    logic       q1;
    logic       q2;
    logic [2:0] taps;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic r, input logic dd, input logic e1,
                     input logic e2, input logic [2:0] et);
    vec_t v;
    v.name = n; v.rst = r; v.d = dd; v.q1 = e1; v.q2 = e2; v.taps = et;
    vecs.push_back(v);
  endtask

  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // Inputs change just after an edge; outputs are read 1 time unit after
  // the next edge.
  task automatic step(input logic r, input logic dd);
    rst = r;
    d   = dd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with d=1 held, over two edges.
    add("reset_e1", 1, 1, 0, 0, 3'b000);
    add("reset_e2", 1, 1, 0, 0, 3'b000);
    // Single pulse.
    add("pulse_e1", 0, 1, 1, 0, 3'b001);
    add("pulse_e2", 0, 0, 0, 0, 3'b010);
    add("pulse_e3", 0, 0, 0, 1, 3'b100);
    add("pulse_e4", 0, 0, 0, 0, 3'b000);
    // Sequence 0,1,1,1,0,0,0,1.
    add("seq_e1", 0, 0, 0, 0, 3'b000);
    add("seq_e2", 0, 1, 1, 0, 3'b001);
    add("seq_e3", 0, 1, 1, 0, 3'b011);
    add("seq_e4", 0, 1, 1, 1, 3'b111);
    add("seq_e5", 0, 0, 0, 1, 3'b110);
    add("seq_e6", 0, 0, 0, 1, 3'b100);
    add("seq_e7", 0, 0, 0, 0, 3'b000);
    add("seq_e8", 0, 1, 1, 0, 3'b001);
    // Constant d=1 from reset; the reset edge also sees d=1.
    add("const_rst", 1, 1, 0, 0, 3'b000);
    add("const_e1", 0, 1, 1, 0, 3'b001);
    add("const_e2", 0, 1, 1, 0, 3'b011);
    add("const_e3", 0, 1, 1, 1, 3'b111);
    add("const_e4", 0, 1, 1, 1, 3'b111);

    #1;
    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].d);
      chk({vecs[i].name, ".q1"},   {15'd0, q1_3},   {15'd0, vecs[i].q1});
      chk({vecs[i].name, ".q2"},   {15'd0, q2_3},   {15'd0, vecs[i].q2});
      chk({vecs[i].name, ".taps"}, {13'd0, taps_3}, {13'd0, vecs[i].taps});
    end

    // Mid-stream reset: load 1,1,1, then pulse rst between edges.
    step(0, 1);
    step(0, 1);
    step(0, 1);
    chk("mid_loaded.taps", {13'd0, taps_3}, 16'h0007);
    #2 rst = 1'b1;
    #1;
    chk("mid_async.q1",   {15'd0, q1_3},   16'h0000);
    chk("mid_async.q2",   {15'd0, q2_3},   16'h0000);
    chk("mid_async.taps", {13'd0, taps_3}, 16'h0000);
    #1 rst = 1'b0;
    d = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      step(0, 0);
      chk($sformatf("mid_post_e%0d.q2", e),   {15'd0, q2_3},   16'h0000);
      chk($sformatf("mid_post_e%0d.taps", e), {13'd0, taps_3}, 16'h0000);
    end

    // Parameter sweep: one pulse, watch it arrive in the DEPTH=2 and
    // DEPTH=16 instances.
    step(1, 0);
    step(0, 1);
    for (int n = 1; n <= 18; n++) begin
      if (n > 1) step(0, 0);
      chk($sformatf("sweep_e%0d.q1_d2", n),  {15'd0, q1_2},  {15'd0, (n == 1)});
      chk($sformatf("sweep_e%0d.q1_d16", n), {15'd0, q1_16}, {15'd0, (n == 1)});
      chk($sformatf("sweep_e%0d.q2_d2", n),  {15'd0, q2_2},  {15'd0, (n == 2)});
      chk($sformatf("sweep_e%0d.q2_d16", n), {15'd0, q2_16}, {15'd0, (n == 16)});
      chk($sformatf("sweep_e%0d.q2_d3", n),  {15'd0, q2_3},  {15'd0, (n == 3)});
    end
    chk("sweep_end.taps_d16", taps_16, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
